square_wave_meter: RTL and testbench

SQUARE_WAVE_METER -- requirements
Module: square_wave_meter

---
 rtl/fpga_clock_pkg.sv | 13 +
 rtl/edge_sync.sv | 31 +++
 rtl/square_wave_meter.sv | 134 +++++++++++++
 tb/tb_square_wave_meter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fpga_clock_pkg.sv
// Shared definitions for the clock/waveform measurement blocks: FSM state
// encoding of the square-wave meter and its default loss-of-lock timeout.
package fpga_clock_pkg;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } meter_state_e;

  // 1 s at 100 MHz without a rising edge drops lock.
  localparam logic [31:0] TIMEOUT_DEFAULT = 32'd100_000_000;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous level plus a history flop, giving
// the synchronized level and single-cycle rise/fall strobes.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // s1/s2 resolve metastability, s3 holds the previous synchronized level
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/square_wave_meter.sv
// Square-wave meter: measures rising-to-rising period and rising-to-falling
// high time of an asynchronous input in clk cycles, tracks lock and flags a
// timeout when no rising edge arrives within TIMEOUT cycles.
// Optional build macro SQUARE_WAVE_METER_DUTY_EN enables high-time capture;
// without it the fall path is dropped and high_time reads 0.
module square_wave_meter
  import fpga_clock_pkg::*;
#(
  parameter int          CNT_W   = 32,
  parameter logic [31:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  meter_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, period_nxt;
  logic             meas_nxt, locked_nxt, timeout_nxt;
  logic             level, rise, fall;
  logic             unused_sync;

  edge_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (sw_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_FIRST;
    else     state <= state_nxt;
  end

  // Next state, counter and status decode; a rise always beats the timeout
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = sat_inc(cnt);
    period_nxt  = period;
    meas_nxt    = 1'b0;
    locked_nxt  = locked;
    timeout_nxt = 1'b0;
    case (state)
      WAIT_FIRST: begin
        if (rise) begin
          state_nxt = MEASURE;
          cnt_nxt   = CNT_ONE;
        end else if (cnt == TIMEOUT_C) begin
          timeout_nxt = 1'b1;
          cnt_nxt     = CNT_ONE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_nxt = cnt;
          meas_nxt   = 1'b1;
          locked_nxt = 1'b1;
          cnt_nxt    = CNT_ONE;
        end else if (cnt == TIMEOUT_C) begin
          state_nxt   = WAIT_FIRST;
          timeout_nxt = 1'b1;
          locked_nxt  = 1'b0;
          cnt_nxt     = CNT_ONE;
        end
      end
      default: state_nxt = WAIT_FIRST;
    endcase
  end

  // Interval counter, published period and status strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      period     <= period_nxt;
      meas_valid <= meas_nxt;
      locked     <= locked_nxt;
      timeout    <= timeout_nxt;
    end
  end

`ifdef SQUARE_WAVE_METER_DUTY_EN
  logic [CNT_W-1:0] hi_cnt, hi_nxt, high_nxt;

  // Latch high time on fall; publish it with the period on the next rise.
  // Without an intervening fall the previous hi_cnt is reported again.
  always_comb begin
    hi_nxt   = hi_cnt;
    high_nxt = high_time;
    if (state == MEASURE) begin
      if (fall) hi_nxt   = cnt;
      if (rise) high_nxt = hi_cnt;
    end
  end

  // High-time capture and published high_time registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_cnt    <= '0;
      high_time <= '0;
    end else begin
      hi_cnt    <= hi_nxt;
      high_time <= high_nxt;
    end
  end

  assign unused_sync = level;
`else
  assign high_time   = '0;
  assign unused_sync = level ^ fall;
`endif

endmodule

// File: tb/tb_square_wave_meter.sv
// Scoreboard bench for square_wave_meter (TIMEOUT = 50). The driver feeds
// sw_in one sample per cycle and a reference model pushes expected events
// (measurement or timeout, with the cycle it must appear) into a queue; a
// monitor pops and compares whenever meas_valid or timeout is seen.
module tb_square_wave_meter;

  localparam int CNT_W = 32;
  localparam int T     = 50;
  localparam int LAT   = 3;   // sample driven -> event visible

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sw_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic             meas_valid, locked, timeout;

  square_wave_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (32'd50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_in      (sw_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_to;
    int          t;
    logic [31:0] per;
    logic [31:0] ht;
    bit          lk;
  } exp_t;

  exp_t q[$];

  // Reference model state, in terms of sample times
  int          restart;     // time of the last counter restart
  bit          measuring;   // an arming rise has been seen
  logic [31:0] m_hi;        // last rise-to-fall distance
  logic [31:0] m_per;       // last reported period
  logic [31:0] m_ht;        // last reported high time
  logic        prev_v;

  function void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (cyc %0d)", name, act, req, cyc);
    end
  endfunction

  function void push(input bit is_to, input int t, input bit lk);
    exp_t e;
    e.is_to = is_to;
    e.t     = t;
    e.per   = m_per;
    e.ht    = m_ht;
    e.lk    = lk;
    q.push_back(e);
  endfunction

  // Every TIMEOUT cycles without a rise (strictly before d) is a timeout.
  function void advance(input int d);
    while (restart + T < d) begin
      push(1'b1, restart + T + LAT, 1'b0);
      restart   = restart + T;
      measuring = 1'b0;
    end
  endfunction

  function void model_sample(input int d, input logic v);
    advance(d);
    if (v && !prev_v) begin
      if (measuring) begin
        m_per = 32'(d - restart);
`ifdef SQUARE_WAVE_METER_DUTY_EN
        m_ht = m_hi;
`else
        m_ht = 32'd0;
`endif
        push(1'b0, d + LAT, 1'b1);
      end
      measuring = 1'b1;
      restart   = d;
    end else if (!v && prev_v && measuring) begin
      m_hi = 32'(d - restart);
    end
    prev_v = v;
  endfunction

  // Reset edge closes interval dr: anything due later is discarded.
  function void model_reset(input int dr);
    while (q.size() > 0 && q[q.size()-1].t > dr) void'(q.pop_back());
    restart   = dr - 1;
    measuring = 1'b0;
    m_hi      = '0;
    m_per     = '0;
    m_ht      = '0;
    prev_v    = 1'b0;
  endfunction

  task automatic step(input logic v);
    @(negedge clk);
    sw_in = v;
    model_sample(cyc, v);
  endtask

  task automatic wave(input int hi, input int lo);
    repeat (hi) step(1'b1);
    repeat (lo) step(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    sw_in = 1'b0;
    model_reset(cyc);
    @(negedge clk);
    rst   = 1'b0;
    sw_in = 1'b0;
    model_sample(cyc, 1'b0);
    chk("rst_period", period, 32'd0);
    chk("rst_high_time", high_time, 32'd0);
    chk("rst_meas_valid", 32'(meas_valid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
  endtask

  task automatic pulse_reset();
    repeat (4) step(1'b0);
    do_reset();
  endtask

  // Monitor: compare every presented event against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (meas_valid === 1'b1 || timeout === 1'b1) begin
        chk("exclusive", 32'(meas_valid & timeout), 32'd0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: actual meas_valid=%0b timeout=%0b required none (cyc %0d)",
                   meas_valid, timeout, cyc);
        end else begin
          e = q.pop_front();
          chk("event_is_timeout", 32'(timeout), 32'(e.is_to));
          chk("event_cycle", 32'(cyc), 32'(e.t));
          chk("period", period, e.per);
          chk("high_time", high_time, e.ht);
          chk("locked", 32'(locked), 32'(e.lk));
        end
      end
    end
  end

  // Stimulus
  initial begin
    int hi, lo;
    repeat (3) @(negedge clk);
    do_reset();

    repeat (5) wave(5, 5);          // period 10, 50% duty
    repeat (4) wave(2, 5);          // period 7, high 2
    repeat (3) wave(5, 5);          // relock at 10
    wave(5, 130);                   // input stops: lock lost, then idle timeout
    repeat (3) wave(5, 5);
    wave(5, 45);                    // rise exactly at cnt == TIMEOUT
    repeat (2) wave(5, 5);
    wave(5, 46);                    // one cycle too late
    repeat (3) wave(4, 4);
    wave(60, 5);                    // times out while high, falls while idle
    repeat (3) wave(4, 4);
    repeat (2) wave(5, 5);
    repeat (3) step(1'b1);          // reset in the middle of a period
    pulse_reset();
    repeat (3) wave(4, 5);

    for (int i = 0; i < 40; i++) begin
      hi = $urandom_range(2, 30);
      lo = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 120) : $urandom_range(2, 30);
      wave(hi, lo);
      if ($urandom_range(0, 14) == 0) pulse_reset();
    end

    repeat (20) step(1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
